ad9958_profile_sequencer: RTL

- Drives the ftw_ch0/ftw_ch1/asf_ch0/asf_ch1 inputs of the AD9958 core from a host-loaded table of up to 2^DEPTH_LOG2 profile entries.
- Steps through the entries in lock-step with the core's io_update pulses. Each entry is held for a programmable number of update cycles.
- Supports one-shot and looping frequency/amplitude sweeps without host intervention.
- Sits between the host register interface and the core, in the same clock domain as the core.

---
 rtl/ad9958_profile_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ad9958_profile_sequencer.sv
// Steps the AD9958 FTW/ASF inputs through a host-loaded profile table, advancing on io_update rising edges.
// Latency: outputs change one cycle after the upd strobe; there is no backpressure, and writes are accepted in any state.
module ad9958_profile_sequencer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DWELL_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_ftw_ch0,
    input  logic [31:0]           wr_ftw_ch1,
    input  logic [9:0]            wr_asf_ch0,
    input  logic [9:0]            wr_asf_ch1,
    input  logic [DWELL_W-1:0]    wr_dwell,
    input  logic [DEPTH_LOG2-1:0] last_index,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  io_update,
    output logic [31:0]           ftw_ch0,
    output logic [31:0]           ftw_ch1,
    output logic [9:0]            asf_ch0,
    output logic [9:0]            asf_ch1,
    output logic                  running,
    output logic [DEPTH_LOG2-1:0] index,
    output logic                  done
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nxt;
    logic [31:0]             ftw0_mem  [DEPTH];
    logic [31:0]             ftw1_mem  [DEPTH];
    logic [9:0]              asf0_mem  [DEPTH];
    logic [9:0]              asf1_mem  [DEPTH];
    logic [DWELL_W-1:0]      dwell_mem [DEPTH];
    logic                    io_update_q;
    logic                    upd;
    logic [DWELL_W-1:0]      dwell_cnt;
    logic [DEPTH_LOG2-1:0]   last_cap;
    logic                    loop_cap;
    logic                    load;
    logic                    capture;
    logic                    dwell_dec;
    logic                    done_nxt;
    logic [DEPTH_LOG2-1:0]   load_addr;
    logic [DWELL_W-1:0]      load_dwell;

    assign upd        = io_update & ~io_update_q;
    assign load_dwell = dwell_mem[load_addr];

    // Loads read the array before this edge's write lands, so a same-entry
    // write in the load cycle is only seen on the next load.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ftw0_mem[i]  <= '0;
                ftw1_mem[i]  <= '0;
                asf0_mem[i]  <= '0;
                asf1_mem[i]  <= '0;
                dwell_mem[i] <= '0;
            end
        end else if (wr_en) begin
            ftw0_mem[wr_addr]  <= wr_ftw_ch0;
            ftw1_mem[wr_addr]  <= wr_ftw_ch1;
            asf0_mem[wr_addr]  <= wr_asf_ch0;
            asf1_mem[wr_addr]  <= wr_asf_ch1;
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_addr = '0;
        capture   = 1'b0;
        dwell_dec = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                    capture   = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (upd) begin
                    if (dwell_cnt > DWELL_ONE) begin
                        dwell_dec = 1'b1;
                    end else if (index != last_cap) begin
                        load      = 1'b1;
                        load_addr = index + 1'b1;
                    end else if (loop_cap) begin
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            io_update_q <= 1'b0;
            dwell_cnt   <= '0;
            last_cap    <= '0;
            loop_cap    <= 1'b0;
            ftw_ch0     <= '0;
            ftw_ch1     <= '0;
            asf_ch0     <= '0;
            asf_ch1     <= '0;
            index       <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            io_update_q <= io_update;
            running     <= (state_nxt == RUN);
            done        <= done_nxt;
            if (capture) begin
                last_cap <= last_index;
                loop_cap <= loop_en;
            end
            if (load) begin
                ftw_ch0   <= ftw0_mem[load_addr];
                ftw_ch1   <= ftw1_mem[load_addr];
                asf_ch0   <= asf0_mem[load_addr];
                asf_ch1   <= asf1_mem[load_addr];
                index     <= load_addr;
                dwell_cnt <= (load_dwell == '0) ? DWELL_ONE : load_dwell;
            end else if (dwell_dec) begin
                dwell_cnt <= dwell_cnt - DWELL_ONE;
            end
        end
    end
endmodule
